spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//   Parametrised SPI master, successor to our fixed-mode 8-bit core. Adds the following:
//   - configurable word width and bit order;
//   - run-time SPI mode (CPOL/CPHA) and SCLK divider, latched per transfer;
//   - multiple slave selects and explicit CS setup/hold phases.
//   Sits between the CPU-side register bus (cs/rd/wr strobes) and the external SPI pins.
// PARAMETERS
//   DWIDTH     8  bits per transfer (>=2)
//   DIV_W      8  width of run-time divider input
//   NUM_SS     1  number of slave-select outputs
//   SS_W       1  width of slave index input; must be >= clog2(NUM_SS), min 1
//   LSB_FIRST  0  0 = MSB shifted first, 1 = LSB first
// PORTS
//   clk    in   1       system clock
//   rst    in   1       synchronous, active-high reset
//   cs     in   1       block select for bus strobes
//   rd     in   1       read strobe; cs&rd&~wr clears done
//   wr     in   1       write strobe; cs&wr&~rd&~busy starts a transfer
//   din    in   DWIDTH  transmit word, sampled on start
//   cpol   in   1       clock polarity, sampled on start
//   cpha   in   1       clock phase, sampled on start
//   div    in   DIV_W   SCLK half-period = div+1 clk cycles, sampled on start
//   ss_sel in   SS_W    slave index, sampled on start; index >= NUM_SS -> no ss_n asserted
//   dout   out  DWIDTH  last received word; valid while done=1
//   busy   out  1       transfer in progress
//   done   out  1       sticky completion flag
//   miso   in   1       serial in
//   mosi   out  1       serial out
//   sclk   out  1       serial clock
//   ss_n   out  NUM_SS  active-low slave selects
// BEHAVIOUR
//   Reset (sync, rst=1 at a clk edge):
//   - dout=0, busy=0, done=0, mosi=0, sclk=0, ss_n=all 1s, state=IDLE.
//   - Latched cpol is cleared to 0.
//   - Reset mid-transfer aborts at once; no partial dout update.
//   States and transitions:
//   - IDLE -> LEAD on accepted start, at edge N. At that edge:
//     latch din/cpol/cpha/div/ss_sel; busy<=1; done<=0; ss_n[sel]<=0.
//     CPHA=0: mosi <= first bit.
//   - LEAD: hold (div+1) cycles (CS setup); sclk at idle level (=cpol).
//   - XFER: 2*DWIDTH sclk toggles, one every (div+1) cycles.
//     CPHA=0: sample miso on leading edge; drive next bit on trailing edge.
//     CPHA=1: drive bit on leading edge; sample on trailing edge.
//     Leading edge = toggle away from cpol.
//   - TAIL: hold (div+1) cycles, sclk=cpol.
//   - TAIL -> IDLE. At that edge: ss_n<=all 1s; busy<=0; done<=1; dout<=received word.
//   Timing: busy high for exactly (2*DWIDTH+2)*(div+1) cycles.
//   Idle outputs: sclk idles at the latched cpol of the last transfer (0 after reset).
//   Boundary conditions:
//   - wr while busy: ignored, no side effects.
//   - rd&wr together: ignored.
//   - rd clear of done coincident with completion: completion wins, done=1.
//   - div=0: SCLK = clk/2.
//   - div at its maximum value: no overflow; the counter is DIV_W bits, reloaded with div.
//   Bit order: per LSB_FIRST, identical for tx and rx.
// STRUCTURE
//   Shared header spi_defs.vh:
//   - state encodings IDLE/LEAD/XFER/TAIL;
//   - mode constants (MODE0..MODE3 = {cpol,cpha}).
//   Sub-module spi_clk_gen:
//   - DIV_W down-counter and sclk toggle logic;
//   - emits one-cycle lead_stb/trail_stb strobes and an edge count.
//   - Top level holds the FSM, shift registers and bus handshake.
// TESTING
//   All scenarios use DWIDTH=8, NUM_SS=2.
//   1. Mode 0, div=0, din=0xA5, sel=0, mosi looped to miso
//      -> dout=0xA5, busy 18 cycles, 8 rising sclk, ss_n=2'b10 during.
//   2. Mode 3, div=3, miso=1
//      -> sclk idles 1, half-period 4 clks, busy 72 cycles, dout=0xFF, done=1.
//   3. Mode 1, din=0x3C; second wr with 0xFF mid-transfer
//      -> second ignored, mosi stream 0,0,1,1,1,1,0,0.
//   4. rst asserted in XFER
//      -> next cycle: busy=0, ss_n=2'b11, sclk=0, done=0, dout=0.
//   5. cs&rd&wr together in IDLE -> no start.
//      cs&rd after completion -> done 1->0, dout unchanged.
//   6. LSB_FIRST=1 build, din=0x01 -> first mosi bit 1, then seven 0s.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master: FSM state encoding, SPI mode
// constants ({cpol,cpha}) and a helper selecting the sampling edge.
package spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_XFER = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // CPHA=0 samples on the leading edge, CPHA=1 on the trailing one.
    function automatic logic sample_now(input logic cpha,
                                        input logic lead,
                                        input logic trail);
        return cpha ? trail : lead;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Bus + pin bundle of the SPI master. master: the spi_master side;
// slave: the CPU bus / pin environment that drives it.
interface spi_master_if #(
    parameter int DWIDTH = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_SS = 1,
    parameter int SS_W   = 1
);
    logic              cs;
    logic              rd;
    logic              wr;
    logic [DWIDTH-1:0] din;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  div;
    logic [SS_W-1:0]   ss_sel;
    logic [DWIDTH-1:0] dout;
    logic              busy;
    logic              done;
    logic              miso;
    logic              mosi;
    logic              sclk;
    logic [NUM_SS-1:0] ss_n;

    modport master (
        input  cs, rd, wr, din, cpol, cpha, div, ss_sel, miso,
        output dout, busy, done, mosi, sclk, ss_n
    );

    modport slave (
        output cs, rd, wr, din, cpol, cpha, div, ss_sel, miso,
        input  dout, busy, done, mosi, sclk, ss_n
    );
endinterface

// File: rtl/spi_master_clk_gen.sv
// SCLK generator: DIV_W down-counter ticking every (div+1) clks, sclk
// toggle, lead/trail strobes and edge count. Ports: i_load (latch
// div/cpol), i_run (counting), i_xfer (toggle enable), o_* strobes.
module spi_master_clk_gen #(
    parameter int DWIDTH = 8,
    parameter int DIV_W  = 8,
    parameter int EW     = $clog2(2*DWIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_cpol,
    input  logic             i_run,
    input  logic             i_xfer,
    output logic             o_tick,
    output logic             o_lead_stb,
    output logic             o_trail_stb,
    output logic [EW-1:0]    o_edge_cnt,
    output logic             o_sclk
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic [EW-1:0]    r_edge;
    logic             w_tick;

    assign w_tick = i_run && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_div  <= '0;
            r_sclk <= 1'b0;
            r_edge <= '0;
        end else if (i_load) begin
            r_cnt  <= i_div;
            r_div  <= i_div;
            r_sclk <= i_cpol;
            r_edge <= '0;
        end else if (i_run) begin
            if (w_tick) begin
                r_cnt <= r_div;
                if (i_xfer) begin
                    r_sclk <= ~r_sclk;
                    r_edge <= r_edge + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Even edges leave the idle level, odd edges return to it.
    assign o_tick      = w_tick;
    assign o_lead_stb  = w_tick && i_xfer && !r_edge[0];
    assign o_trail_stb = w_tick && i_xfer && r_edge[0];
    assign o_edge_cnt  = r_edge;
    assign o_sclk      = r_sclk;
endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master: FSM, tx/rx shift registers, bus handshake.
// Ports: clk, rst (sync, active high), bus (spi_master_if.master).
module spi_master
    import spi_master_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int DIV_W     = 8,
    parameter int NUM_SS    = 1,
    parameter int SS_W      = 1,
    parameter int LSB_FIRST = 0
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);
    localparam int EW = $clog2(2*DWIDTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DWIDTH-1:0] r_tx;
    logic [DWIDTH-1:0] r_rx;
    logic [DWIDTH-1:0] r_dout;
    logic              r_cpha;
    logic              r_mosi;
    logic              r_done;
    logic [NUM_SS-1:0] r_ss_n;
    logic [NUM_SS-1:0] w_ss_dec;
    logic [DWIDTH-1:0] w_tx_sh;
    logic [DWIDTH-1:0] w_rx_in;
    logic              w_din_first;
    logic              w_tx_first;
    logic              w_sh_first;
    logic              w_start;
    logic              w_clear;
    logic              w_finish;
    logic              w_tick;
    logic              w_lead;
    logic              w_trail;
    logic              w_last;
    logic              w_sclk;
    logic [EW-1:0]     w_edge;

    spi_master_clk_gen #(
        .DWIDTH (DWIDTH),
        .DIV_W  (DIV_W)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_start),
        .i_div       (bus.div),
        .i_cpol      (bus.cpol),
        .i_run       (r_state != ST_IDLE),
        .i_xfer      (r_state == ST_XFER),
        .o_tick      (w_tick),
        .o_lead_stb  (w_lead),
        .o_trail_stb (w_trail),
        .o_edge_cnt  (w_edge),
        .o_sclk      (w_sclk)
    );

    assign w_start  = bus.cs && bus.wr && !bus.rd
                      && (r_state == ST_IDLE);
    assign w_clear  = bus.cs && bus.rd && !bus.wr;
    assign w_last   = w_trail && (w_edge == EW'(2*DWIDTH-1));
    assign w_finish = (r_state == ST_TAIL) && w_tick;

    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            w_ss_dec[i] = (bus.ss_sel != SS_W'(i));
        end
    end

    // Same bit order for both directions.
    always_comb begin
        if (LSB_FIRST != 0) begin
            w_tx_sh     = r_tx >> 1;
            w_rx_in     = {bus.miso, r_rx[DWIDTH-1:1]};
            w_din_first = bus.din[0];
            w_tx_first  = r_tx[0];
            w_sh_first  = r_tx[1];
        end else begin
            w_tx_sh     = r_tx << 1;
            w_rx_in     = {r_rx[DWIDTH-2:0], bus.miso};
            w_din_first = bus.din[DWIDTH-1];
            w_tx_first  = r_tx[DWIDTH-1];
            w_sh_first  = r_tx[DWIDTH-2];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_LEAD;
            ST_LEAD: if (w_tick)  w_state_nxt = ST_XFER;
            ST_XFER: if (w_last)  w_state_nxt = ST_TAIL;
            ST_TAIL: if (w_tick)  w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= '0;
            r_rx   <= '0;
            r_dout <= '0;
            r_cpha <= 1'b0;
            r_mosi <= 1'b0;
            r_done <= 1'b0;
            r_ss_n <= '1;
        end else if (w_start) begin
            r_tx   <= bus.din;
            r_cpha <= bus.cpha;
            r_done <= 1'b0;
            r_ss_n <= w_ss_dec;
            if (!bus.cpha) r_mosi <= w_din_first;
        end else begin
            // CPHA=1 drives on lead; CPHA=0 drives the next bit on trail.
            if (w_lead && r_cpha) begin
                r_mosi <= w_tx_first;
                r_tx   <= w_tx_sh;
            end
            if (w_trail && !r_cpha) begin
                r_mosi <= w_sh_first;
                r_tx   <= w_tx_sh;
            end
            if (sample_now(r_cpha, w_lead, w_trail)) r_rx <= w_rx_in;
            // Completion beats a coincident read-clear.
            if (w_finish) begin
                r_ss_n <= '1;
                r_done <= 1'b1;
                r_dout <= r_rx;
            end else if (w_clear) begin
                r_done <= 1'b0;
            end
        end
    end

    assign bus.dout = r_dout;
    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;
    assign bus.mosi = r_mosi;
    assign bus.sclk = w_sclk;
    assign bus.ss_n = r_ss_n;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: random transfers checked against an
// SPI slave model; plus reset, handshake and LSB-first checks.
module tb_spi_master;
    import spi_master_pkg::*;

    typedef struct {
        logic [7:0] dout;
        logic [7:0] mw;
        int         cycles;
        logic [1:0] ss;
        logic       cpol;
        logic       cpha;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    bit         cur_loop = 1'b0;
    logic [7:0] cur_sw   = 8'h00;

    spi_master_if #(.DWIDTH(8), .DIV_W(8), .NUM_SS(2), .SS_W(1)) ifa();
    spi_master_if #(.DWIDTH(8), .DIV_W(8), .NUM_SS(2), .SS_W(1)) ifb();

    spi_master #(
        .DWIDTH(8), .DIV_W(8), .NUM_SS(2), .SS_W(1), .LSB_FIRST(0)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    spi_master #(
        .DWIDTH(8), .DIV_W(8), .NUM_SS(2), .SS_W(1), .LSB_FIRST(1)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    assign ifb.miso = ifb.mosi;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave presents bit j after (CPHA=0) trailing / (CPHA=1) leading edges.
    function automatic logic sbit(input logic [7:0] w, input int ed,
                                  input logic ph);
        int j;
        j = ph ? ((ed == 0) ? 0 : (ed - 1) / 2) : ed / 2;
        if (j > 7) j = 7;
        return w[7 - j];
    endfunction

    // Monitor: slave model, mosi capture and completion scoreboard.
    bit         p_busy = 1'b0;
    logic       p_sclk = 1'b0;
    int         edges  = 0;
    int         bcnt   = 0;
    logic [1:0] ss_seen = 2'b11;
    logic [7:0] mword  = 8'h00;

    always @(negedge clk) begin
        logic ph;
        exp_t e;
        ph = (sb.size() > 0) ? sb[0].cpha : 1'b0;
        if (rst) begin
            p_busy = 1'b0;
        end else begin
            if (ifa.busy && !p_busy) begin
                edges   = 0;
                p_sclk  = ifa.sclk;
                bcnt    = 1;
                ss_seen = ifa.ss_n;
                mword   = 8'h00;
            end else if (ifa.busy) begin
                bcnt++;
                if (ifa.sclk != p_sclk) begin
                    edges++;
                    p_sclk = ifa.sclk;
                    if ((edges % 2) == (ph ? 0 : 1))
                        mword = {mword[6:0], ifa.mosi};
                end
            end else if (p_busy) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got completion, expected none");
                end else begin
                    e = sb.pop_front();
                    check("dout", ifa.dout, e.dout);
                    check("mosi_stream", mword, e.mw);
                    check("busy_cycles", bcnt, e.cycles);
                    check("sclk_edges", edges, 16);
                    check("ss_during", ss_seen, e.ss);
                    check("done_set", ifa.done, 1);
                    check("ss_idle", ifa.ss_n, 2'b11);
                    check("sclk_idle", ifa.sclk, e.cpol);
                end
            end
            p_busy = ifa.busy;
        end
        ifa.miso = cur_loop ? ifa.mosi : sbit(cur_sw, edges, ph);
    end

    task automatic wait_idle();
        int c = 0;
        while (ifa.busy === 1'b1 && c < 6000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("busy_timeout", ifa.busy, 0);
    endtask

    // action: 0 plain, 1 stray wr while busy, 2 hold rd to completion
    task automatic xfer(input logic [7:0] d, input logic [1:0] mode,
                        input logic [7:0] dv, input logic sel,
                        input bit loop, input logic [7:0] sw,
                        input int action);
        exp_t e;
        @(posedge clk);
        #1;
        cur_loop = loop;
        cur_sw   = sw;
        e.dout   = loop ? d : sw;
        e.mw     = d;
        e.cycles = 18 * (int'(dv) + 1);
        e.ss     = sel ? 2'b01 : 2'b10;
        e.cpol   = mode[1];
        e.cpha   = mode[0];
        sb.push_back(e);
        ifa.cs = 1'b1; ifa.wr = 1'b1; ifa.rd = 1'b0;
        ifa.din = d; {ifa.cpol, ifa.cpha} = mode;
        ifa.div = dv; ifa.ss_sel = sel;
        @(posedge clk);
        #1;
        ifa.cs = 1'b0; ifa.wr = 1'b0;
        ifa.din = 8'($urandom); ifa.cpol = 1'($urandom);
        ifa.cpha = 1'($urandom); ifa.div = 8'($urandom);
        ifa.ss_sel = 1'($urandom);
        if (action == 1) begin
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #1;
            ifa.cs = 1'b1; ifa.wr = 1'b1; ifa.din = ~d;
            @(posedge clk);
            #1;
            ifa.cs = 1'b0; ifa.wr = 1'b0;
        end else if (action == 2) begin
            ifa.cs = 1'b1; ifa.rd = 1'b1;
        end
        wait_idle();
        ifa.cs = 1'b0; ifa.rd = 1'b0;
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic xfer_b(input logic [7:0] d);
        logic [7:0] got;
        int         k;
        logic       prev;
        @(posedge clk);
        #1;
        ifb.cs = 1'b1; ifb.wr = 1'b1; ifb.din = d;
        ifb.cpol = 1'b0; ifb.cpha = 1'b0; ifb.div = 8'd0;
        @(posedge clk);
        #1;
        ifb.cs = 1'b0; ifb.wr = 1'b0;
        got  = 8'h00;
        k    = 0;
        prev = ifb.sclk;
        for (int c = 0; c < 200 && ifb.busy; c++) begin
            @(negedge clk);
            if (ifb.sclk && !prev && k < 8) begin
                got[k] = ifb.mosi;
                k++;
            end
            prev = ifb.sclk;
        end
        check("lsb_busy_timeout", ifb.busy, 0);
        check("lsb_bits", k, 8);
        check("lsb_mosi_stream", got, d);
        check("lsb_dout", ifb.dout, d);
        check("lsb_done", ifb.done, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        ifa.cs = 0; ifa.rd = 0; ifa.wr = 0; ifa.din = 0;
        ifa.cpol = 0; ifa.cpha = 0; ifa.div = 0; ifa.ss_sel = 0;
        ifb.cs = 0; ifb.rd = 0; ifb.wr = 0; ifb.din = 0;
        ifb.cpol = 0; ifb.cpha = 0; ifb.div = 0; ifb.ss_sel = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        check("rst_dout", ifa.dout, 0);
        check("rst_sclk", ifa.sclk, 0);
        check("rst_ss_n", ifa.ss_n, 2'b11);
        check("rst_mosi", ifa.mosi, 0);
        rst = 1'b0;

        xfer(8'hA5, MODE0, 8'd0, 1'b0, 1'b1, 8'h00, 0);
        xfer(8'h5A, MODE3, 8'd3, 1'b1, 1'b0, 8'hFF, 0);

        // Reset while in XFER aborts with no dout update.
        @(posedge clk);
        #1;
        cur_loop = 1'b1;
        ifa.cs = 1; ifa.wr = 1; ifa.din = 8'h33;
        {ifa.cpol, ifa.cpha} = MODE3; ifa.div = 8'd1; ifa.ss_sel = 0;
        @(posedge clk);
        #1;
        ifa.cs = 0; ifa.wr = 0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", ifa.busy, 0);
        check("abort_ss_n", ifa.ss_n, 2'b11);
        check("abort_sclk", ifa.sclk, 0);
        check("abort_done", ifa.done, 0);
        check("abort_dout", ifa.dout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        xfer(8'h3C, MODE1, 8'd1, 1'b0, 1'b1, 8'h00, 1);

        // rd&wr together: no start.
        @(posedge clk);
        #1;
        ifa.cs = 1; ifa.rd = 1; ifa.wr = 1; ifa.din = 8'h77;
        @(posedge clk);
        #1;
        check("rdwr_no_start", ifa.busy, 0);
        ifa.cs = 0; ifa.rd = 0; ifa.wr = 0;
        check("done_before_rd", ifa.done, 1);
        ifa.cs = 1; ifa.rd = 1;
        @(posedge clk);
        #1;
        ifa.cs = 0; ifa.rd = 0;
        check("rd_clears_done", ifa.done, 0);
        check("rd_keeps_dout", ifa.dout, 8'h3C);

        xfer(8'hC3, MODE2, 8'd2, 1'b1, 1'b0, 8'h96, 2);

        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            xfer(d, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 8'($urandom), $urandom_range(0, 2));
        end

        xfer(8'h81, MODE0, 8'hFF, 1'b0, 1'b0, 8'h6E, 0);

        xfer_b(8'h01);
        xfer_b(8'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
